jk_bank_arbiter: RTL and testbench

JK_BANK_ARBITER -- requirements
Module: jk_bank_arbiter

---
 rtl/jk_bank_arbiter.sv | 112 +++++++++++
 tb/tb_jk_bank_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter granting NREQ requesters J/K/set/toggle access to one JK flip-flop bank; JK_ARB_STATS_EN adds cmd_count.
// Latency: gnt 1 cycle after req sampled, done and new Q 3 cycles after; throughput 1 command per 4 cycles, losers wait in req.
module jk_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  localparam int IW   = $clog2(NBITS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    op,
  input  logic [IW*NREQ-1:0]   idx,
  output logic [NREQ-1:0]      gnt,
  output logic [NBITS-1:0]     Q,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          cmd_count
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = PW + 1;

  typedef enum logic [1:0] {IDLE, GRANT, APPLY, DONE} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win;
  logic [PW-1:0]   win_nxt;
  logic            win_found;
  logic [SW-1:0]   cand;
  logic [1:0]      op_cap;
  logic [IW-1:0]   idx_cap;

  // Search upward from ptr, wrapping modulo NREQ; first asserted req wins.
  always_comb begin
    win_found = 1'b0;
    win_nxt   = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr} + SW'(i);
      if (cand >= SW'(NREQ)) cand = cand - SW'(NREQ);
      if (!win_found && req[cand[PW-1:0]]) begin
        win_found = 1'b1;
        win_nxt   = cand[PW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      win     <= '0;
      gnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      Q       <= '0;
      op_cap  <= '0;
      idx_cap <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            win   <= win_nxt;
            gnt   <= NREQ'(1) << win_nxt;
            busy  <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT: begin
          gnt     <= '0;
          op_cap  <= op[2*win +: 2];
          idx_cap <= idx[IW*win +: IW];
          state   <= APPLY;
        end
        APPLY: begin
          case (op_cap)
            2'b01:   Q[idx_cap] <= 1'b0;
            2'b10:   Q[idx_cap] <= 1'b1;
            2'b11:   Q[idx_cap] <= ~Q[idx_cap];
            default: Q[idx_cap] <= Q[idx_cap];
          endcase
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          ptr   <= (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef JK_ARB_STATS_EN
  logic [15:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (state == DONE)
      cnt <= cnt + 16'd1;
  end

  assign cmd_count = cnt;
`else
  assign cmd_count = '0;
`endif

endmodule

// File: tb/tb_jk_bank_arbiter.sv
module tb_jk_bank_arbiter;
  localparam int NREQ  = 4;
  localparam int NBITS = 8;
  localparam int IW    = 3;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req;
  logic [2*NREQ-1:0]   op;
  logic [IW*NREQ-1:0]  idx;
  logic [NREQ-1:0]     gnt;
  logic [NBITS-1:0]    Q;
  logic                busy;
  logic                done;
  logic [15:0]         cmd_count;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [NBITS-1:0] qm;
  int               ptr_m;
  logic [15:0]      cnt_m;

  jk_bank_arbiter #(.NREQ(NREQ), .NBITS(NBITS)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .idx(idx),
    .gnt(gnt), .Q(Q), .busy(busy), .done(done), .cmd_count(cmd_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic logic jk_next(input logic cur, input logic [1:0] jk);
    case (jk)
      2'b00:   return cur;
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      default: return ~cur;
    endcase
  endfunction

  function automatic logic [15:0] exp_count();
`ifdef JK_ARB_STATS_EN
    return cnt_m;
`else
    return 16'd0;
`endif
  endfunction

  // One full command from IDLE back to IDLE; r must be nonzero.
  task automatic run_cmd(input logic [NREQ-1:0] r, input logic [2*NREQ-1:0] o,
                         input logic [IW*NREQ-1:0] ix, input bit drop);
    int w;
    logic [NREQ-1:0] eg;
    logic [1:0] jk;
    int bi;
    w  = pick(r, ptr_m);
    eg = NREQ'(1) << w;
    jk = o[2*w +: 2];
    bi = int'(ix[IW*w +: IW]);
    req = r; op = o; idx = ix;
    step();
    vectors++;
    if (gnt !== eg || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL grant: gnt=%b busy=%b, expected gnt=%b busy=1", gnt, busy, eg);
    end
    if (drop) req = '0;
    step();
    vectors++;
    if (gnt !== '0 || done !== 1'b0 || Q !== qm) begin
      miscompares++;
      $display("FAIL apply: gnt=%b done=%b Q=%h, expected gnt=0 done=0 Q=%h", gnt, done, Q, qm);
    end
    op = NREQ*2'($urandom);
    idx = (IW*NREQ)'($urandom);
    step();
    qm[bi] = jk_next(qm[bi], jk);
    ptr_m = (w + 1) % NREQ;
    cnt_m = cnt_m + 16'd1;
    vectors++;
    if (done !== 1'b1 || Q !== qm || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL done: done=%b Q=%h busy=%b, expected done=1 Q=%h busy=1", done, Q, busy, qm);
    end
    req = '0;
    step();
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || cmd_count !== exp_count()) begin
      miscompares++;
      $display("FAIL idle: busy=%b done=%b cmd_count=%0d, expected 0 0 %0d", busy, done, cmd_count, exp_count());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; op = '0; idx = '0;
    qm = '0; ptr_m = 0; cnt_m = '0;
    step();
    vectors++;
    if (Q !== '0 || gnt !== '0 || done !== 1'b0 || busy !== 1'b0 || cmd_count !== 16'd0) begin
      miscompares++;
      $display("FAIL reset: Q=%h gnt=%b done=%b busy=%b cnt=%0d, expected all 0", Q, gnt, done, busy, cmd_count);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_set();
    run_cmd(4'b0001, 8'b00_00_00_10, 12'(3), 1'b0);
    vectors++;
    if (Q !== 8'h08) begin
      miscompares++;
      $display("FAIL set_q: Q=%h, expected 08", Q);
    end
  endtask

  task automatic test_toggle();
    logic [15:0] c0;
    c0 = cmd_count;
    run_cmd(4'b0100, 8'b00_11_00_00, 12'(3) << 6, 1'b0);
    vectors++;
    if (Q !== 8'h00) begin
      miscompares++;
      $display("FAIL toggle1: Q=%h, expected 00", Q);
    end
    run_cmd(4'b0100, 8'b00_11_00_00, 12'(3) << 6, 1'b1);
    vectors++;
    if (Q !== 8'h08) begin
      miscompares++;
      $display("FAIL toggle2: Q=%h, expected 08", Q);
    end
`ifdef JK_ARB_STATS_EN
    vectors++;
    if (cmd_count !== c0 + 16'd2) begin
      miscompares++;
      $display("FAIL toggle_cnt: cmd_count=%0d, expected %0d", cmd_count, c0 + 16'd2);
    end
`endif
  endtask

  task automatic test_hold();
    for (int b = 0; b < NBITS; b++) begin
      int rq;
      rq = int'($urandom_range(0, NREQ - 1));
      run_cmd(NREQ'(1) << rq, 8'hAA, {NREQ{3'(b)}}, 1'b0);
    end
    vectors++;
    if (Q !== 8'hFF) begin
      miscompares++;
      $display("FAIL fill: Q=%h, expected ff", Q);
    end
    run_cmd(4'b0010, 8'b11_11_00_11, {3'd0, 3'd0, 3'd5, 3'd0}, 1'b0);
    vectors++;
    if (Q !== 8'hFF) begin
      miscompares++;
      $display("FAIL hold: Q=%h, expected ff", Q);
    end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] eg;
    rst_n = 1'b0; req = 4'b1111; op = '0; idx = '0;
    qm = '0; ptr_m = 0; cnt_m = '0;
    step();
    rst_n = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      eg = (c % 4 == 1) ? NREQ'(1) << (((c - 1) / 4) % NREQ) : '0;
      vectors++;
      if (gnt !== eg) begin
        miscompares++;
        $display("FAIL rr_cycle%0d: gnt=%b, expected %b", c, gnt, eg);
      end
    end
    req = '0;
    ptr_m = 1;
    cnt_m = 16'd5;
    vectors++;
    if (cmd_count !== exp_count() || busy !== 1'b0 || Q !== qm) begin
      miscompares++;
      $display("FAIL rr_end: cnt=%0d busy=%b Q=%h, expected %0d 0 %h", cmd_count, busy, Q, exp_count(), qm);
    end
  endtask

  task automatic test_reset_mid();
    req = 4'b1000; op = 8'b10_00_00_00; idx = 12'(7) << 9;
    step();
    vectors++;
    if (gnt !== 4'b1000) begin
      miscompares++;
      $display("FAIL mid_gnt: gnt=%b, expected 1000", gnt);
    end
    step();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (Q !== '0 || busy !== 1'b0 || done !== 1'b0 || gnt !== '0) begin
      miscompares++;
      $display("FAIL mid_abort: Q=%h busy=%b done=%b gnt=%b, expected all 0", Q, busy, done, gnt);
    end
    step();
    vectors++;
    if (done !== 1'b0 || Q !== '0) begin
      miscompares++;
      $display("FAIL mid_hold: done=%b Q=%h, expected 0 00", done, Q);
    end
    rst_n = 1'b1;
    req = '0;
    qm = '0; ptr_m = 0; cnt_m = '0;
    run_cmd(4'b1010, 8'b00_00_10_00, 12'(2) << 3, 1'b0);
  endtask

  task automatic test_random();
    logic [NREQ-1:0] r;
    for (int n = 0; n < 40; n++) begin
      r = NREQ'($urandom);
      if (r == '0) r = NREQ'(1) << $urandom_range(0, NREQ - 1);
      run_cmd(r, (2*NREQ)'($urandom), (IW*NREQ)'($urandom), bit'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_set();
    test_toggle();
    test_hold();
    test_round_robin();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
